// File: rtl/comparator_seq_if.sv
// comparator_seq_if: request/result handshake bundle for comparator_seq.
// master = requester/consumer side, slave = comparator side.
interface comparator_seq_if #(parameter int N = 32);
    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         is_signed;
    logic         o_valid;
    logic         o_ready;
    logic         out;
    logic         o_eq;
    logic         o_lt;
    modport master (output i_valid, a, b, op, is_signed, o_ready,
                    input  i_ready, o_valid, out, o_eq, o_lt);
    modport slave  (input  i_valid, a, b, op, is_signed, o_ready,
                    output i_ready, o_valid, out, o_eq, o_lt);
endinterface

// File: rtl/comparator_seq.sv
// comparator_seq: multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle.
// Define COMPARATOR_SEQ_EARLY_EXIT_EN to finish as soon as the first differing chunk is seen.
module comparator_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst,
    comparator_seq_if.slave   bus
);
    localparam int K  = N / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    if (N % CHUNK != 0) begin : g_bad_chunk
        $error("comparator_seq: N must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            dec_q, dec_d, lt_q, lt_d;
    logic            out_q, out_d, eq_q, eq_d, flt_q, flt_d;
    logic [CHUNK-1:0] ca, cb;
    logic            c_lt, c_ne, last, fin;

    function automatic logic op_out(input logic [2:0] op, input logic eq, input logic lt);
        return op == 3'd0 ? eq :
               op == 3'd1 ? ~eq :
               op == 3'd2 ? lt :
               op == 3'd3 ? lt | eq :
               op == 3'd4 ? ~lt & ~eq :
               op == 3'd5 ? ~lt : 1'b0;
    endfunction

    // Operands shift left each BUSY cycle, so the chunk under test is always the top one.
    always_comb begin
        ca   = a_q[N-1 -: CHUNK];
        cb   = b_q[N-1 -: CHUNK];
        c_lt = 1'b0;
        for (int i = 0; i < CHUNK; i++) c_lt = (~ca[i] & cb[i]) | (~(ca[i] ^ cb[i]) & c_lt);
        c_ne = |(ca ^ cb);
        last = idx_q == IW'(K - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            lt_q    <= 1'b0;
            out_q   <= 1'b0;
            eq_q    <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            lt_q    <= lt_d;
            out_q   <= out_d;
            eq_q    <= eq_d;
            flt_q   <= flt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        lt_d    = lt_q;
        out_d   = out_q;
        eq_d    = eq_q;
        flt_d   = flt_q;
        fin     = 1'b0;
        if (state_q == IDLE && bus.i_valid) begin
            // Flipping both MSBs maps two's-complement order onto unsigned order.
            state_d = BUSY;
            a_d     = bus.a ^ {bus.is_signed, {(N-1){1'b0}}};
            b_d     = bus.b ^ {bus.is_signed, {(N-1){1'b0}}};
            op_d    = bus.op;
            idx_d   = '0;
            dec_d   = 1'b0;
            lt_d    = 1'b0;
        end else if (state_q == BUSY) begin
            dec_d = dec_q | c_ne;
            lt_d  = dec_q ? lt_q : c_lt;
            a_d   = a_q << CHUNK;
            b_d   = b_q << CHUNK;
            idx_d = idx_q + 1'b1;
            fin   = last | (EARLY & dec_d);
            if (fin) begin
                state_d = DONE;
                eq_d    = ~dec_d;
                flt_d   = lt_d;
                out_d   = op_out(op_q, ~dec_d, lt_d);
            end
        end else if (state_q == DONE && bus.o_ready) begin
            state_d = IDLE;
            out_d   = 1'b0;
            eq_d    = 1'b0;
            flt_d   = 1'b0;
        end
    end

    always_comb begin
        bus.i_ready = state_q == IDLE;
        bus.o_valid = state_q == DONE;
        bus.out     = out_q;
        bus.o_eq    = eq_q;
        bus.o_lt    = flt_q;
    end
endmodule

// File: tb/tb_comparator_seq.sv
// tb_comparator_seq: directed + randomized check of comparator_seq against a
// full-width arithmetic model; one negedge monitor checks every valid result cycle.
module tb_comparator_seq;
    localparam int N = 32, CHUNK = 8, K = N / CHUNK;
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0, fails = 0, cyc = 0;

    logic pending = 1'b0, seen = 1'b0;
    logic exp_out, exp_eq, exp_lt;
    int   exp_lat, acc_cyc;
    logic last_out, last_eq, last_lt;
    int   last_lat;

    comparator_seq_if #(.N(N)) bus();
    comparator_seq #(.N(N), .CHUNK(CHUNK)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                                  input logic sgn, output logic o, output logic e, output logic l,
                                  output int lat);
        logic [N-1:0] x;
        e = a == b;
        l = sgn ? ($signed(a) < $signed(b)) : (a < b);
        case (op)
            3'd0: o = e;
            3'd1: o = !e;
            3'd2: o = l;
            3'd3: o = l || e;
            3'd4: o = !l && !e;
            3'd5: o = !l;
            default: o = 1'b0;
        endcase
        lat = K;
        x = a ^ b;
        if (EARLY)
            for (int j = K - 1; j >= 0; j--)
                if (x[N-1-j*CHUNK -: CHUNK] != '0) lat = j + 1;
    endfunction

    always @(negedge clk) if (rst && bus.o_valid) begin
        chk("valid_expected", {31'd0, pending}, 32'd1);
        chk("out", {31'd0, bus.out}, {31'd0, exp_out});
        chk("o_eq", {31'd0, bus.o_eq}, {31'd0, exp_eq});
        chk("o_lt", {31'd0, bus.o_lt}, {31'd0, exp_lt});
        chk("i_ready_in_done", {31'd0, bus.i_ready}, 32'd0);
        if (!seen) begin
            chk("latency", cyc - acc_cyc, exp_lat);
            seen     = 1'b1;
            last_out = bus.out;
            last_eq  = bus.o_eq;
            last_lt  = bus.o_lt;
            last_lat = cyc - acc_cyc;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the result handshake.
    task automatic req(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                       input logic sgn, input int hold, input bit poke);
        int t;
        chk("i_ready_idle", {31'd0, bus.i_ready}, 32'd1);
        bus.a = a; bus.b = b; bus.op = op; bus.is_signed = sgn; bus.i_valid = 1'b1;
        model(a, b, op, sgn, exp_out, exp_eq, exp_lt, exp_lat);
        acc_cyc = cyc + 1;
        seen    = 1'b0;
        pending = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom); bus.is_signed = 1'($urandom);
        t = 0;
        while (!bus.o_valid && t < 3 * K + 5) begin
            @(posedge clk); #1;
            t++;
        end
        chk("o_valid_rise", {31'd0, bus.o_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            bus.i_valid = poke && i == 1;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        @(posedge clk); #1;
        bus.o_ready = 1'b0;
        pending     = 1'b0;
        chk("o_valid_drop", {31'd0, bus.o_valid}, 32'd0);
        chk("i_ready_return", {31'd0, bus.i_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] eq_ops [4] = '{3'd0, 3'd3, 3'd5, 3'd1};
        logic       eq_exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [N-1:0] ra, rb;
        bus.i_valid = 1'b0; bus.o_ready = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.is_signed = 1'b0;
        #12;
        chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_out", {31'd0, bus.out}, 32'd0);
        chk("rst_o_eq", {31'd0, bus.o_eq}, 32'd0);
        chk("rst_o_lt", {31'd0, bus.o_lt}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_i_ready", {31'd0, bus.i_ready}, 32'd1);

        req(32'h12345678, 32'h12345679, 3'd2, 1'b0, 0, 1'b0);
        chk("lt_low_out", {31'd0, last_out}, 32'd1);
        chk("lt_low_lt", {31'd0, last_lt}, 32'd1);
        chk("lt_low_eq", {31'd0, last_eq}, 32'd0);
        chk("lt_low_lat", last_lat, 32'd4);

        req(32'h80000000, 32'h00000001, 3'd2, 1'b1, 1, 1'b0);
        chk("sgn_lt_out", {31'd0, last_out}, 32'd1);
        chk("sgn_lt_lat", last_lat, EARLY ? 32'd1 : 32'd4);
        req(32'h80000000, 32'h00000001, 3'd2, 1'b0, 0, 1'b0);
        chk("uns_lt_out", {31'd0, last_out}, 32'd0);
        req(32'h80000000, 32'h00000001, 3'd4, 1'b0, 0, 1'b0);
        chk("uns_gt_out", {31'd0, last_out}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            req(32'hDEADBEEF, 32'hDEADBEEF, eq_ops[i], 1'b0, i, 1'b0);
            chk("eq_out", {31'd0, last_out}, {31'd0, eq_exp[i]});
            chk("eq_flag", {31'd0, last_eq}, 32'd1);
            chk("eq_lat", last_lat, 32'd4);
        end

        req(32'd5, 32'd3, 3'd4, 1'b0, 6, 1'b1);
        chk("bp_out", {31'd0, last_out}, 32'd1);

        req(32'd0, 32'd1, 3'd7, 1'b0, 0, 1'b0);
        chk("rsv_out", {31'd0, last_out}, 32'd0);
        chk("rsv_lt", {31'd0, last_lt}, 32'd1);
        chk("rsv_eq", {31'd0, last_eq}, 32'd0);

        // Reset two cycles into BUSY; equal operands keep it busy in both builds.
        bus.a = 32'hCAFEF00D; bus.b = 32'hCAFEF00D; bus.op = 3'd0; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("mid_rst_out", {31'd0, bus.out}, 32'd0);
        chk("mid_rst_o_eq", {31'd0, bus.o_eq}, 32'd0);
        chk("mid_rst_o_lt", {31'd0, bus.o_lt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {31'd0, bus.o_valid}, 32'd0);
        end
        @(posedge clk); #1;
        req(32'd1, 32'd2, 3'd2, 1'b0, 0, 1'b0);
        chk("post_rst_out", {31'd0, last_out}, 32'd1);

        for (int n = 0; n < 80; n++) begin
            ra = $urandom;
            case ($urandom_range(3))
                0: rb = ra;
                1: rb = ra ^ (32'd1 << $urandom_range(N - 1));
                default: rb = $urandom;
            endcase
            req(ra, rb, 3'($urandom_range(7)), 1'($urandom), $urandom_range(3), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
